// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the 8-deep FIFO: drains burst_len words onto a valid/ready stream.
// Optional read-ahead skid buffer is enabled with `define FIFO_BURST_READER_PREFETCH_EN.
module fifo_burst_reader #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic              clr,
    input  logic              empty,
    input  logic              rd_ack,
    input  logic              rd_err,
    input  logic [DATA_W-1:0] d_out,
    output logic              rd_en,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        ISSUE = 3'b001,
        WAIT  = 3'b010,
        HOLD  = 3'b011,
        DONE  = 3'b100,
        ERROR = 3'b101
    } state_t;

    state_t            state, state_d;
    logic [LEN_W-1:0]  remaining, remaining_d, remaining_dec;
    logic [DATA_W-1:0] m_data_d;
    logic              m_valid_d;

`ifdef FIFO_BURST_READER_PREFETCH_EN
    logic [DATA_W-1:0] skid, skid_d;
    logic              skid_v, skid_v_d;
    logic [LEN_W-1:0]  issued, issued_d;
    logic [LEN_W-1:0]  burst, burst_d;
    logic              pend, pend_d;
    logic              pf_err, pf_err_d;
    logic              pf_issue, pf_good, pf_bad, xfer;
`endif

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign err  = (state == ERROR);

    // Saturating decrement keeps remaining from wrapping below zero.
    assign remaining_dec = (remaining == '0) ? remaining : remaining - LEN_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            m_data    <= '0;
            m_valid   <= 1'b0;
`ifdef FIFO_BURST_READER_PREFETCH_EN
            skid      <= '0;
            skid_v    <= 1'b0;
            issued    <= '0;
            burst     <= '0;
            pend      <= 1'b0;
            pf_err    <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            remaining <= remaining_d;
            m_data    <= m_data_d;
            m_valid   <= m_valid_d;
`ifdef FIFO_BURST_READER_PREFETCH_EN
            skid      <= skid_d;
            skid_v    <= skid_v_d;
            issued    <= issued_d;
            burst     <= burst_d;
            pend      <= pend_d;
            pf_err    <= pf_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state;
        remaining_d = remaining;
        m_data_d    = m_data;
        m_valid_d   = m_valid;
        rd_en       = 1'b0;
`ifdef FIFO_BURST_READER_PREFETCH_EN
        skid_d      = skid;
        skid_v_d    = skid_v;
        issued_d    = issued;
        burst_d     = burst;
        pend_d      = 1'b0;
        pf_err_d    = pf_err;
        pf_good     = pend & rd_ack & ~rd_err;
        pf_bad      = pend & ~pf_good;
        pf_issue    = ~skid_v & ~pend & ~pf_err & (issued < burst) & ~empty;
        xfer        = m_valid & m_ready;
`endif

        case (state)
            IDLE: begin
                if (start) begin
                    if (burst_len != '0) begin
                        remaining_d = burst_len;
                        state_d     = ISSUE;
                    end else begin
                        state_d = DONE;
                    end
`ifdef FIFO_BURST_READER_PREFETCH_EN
                    burst_d  = burst_len;
                    issued_d = '0;
                    pf_err_d = 1'b0;
                    skid_v_d = 1'b0;
`endif
                end
            end

            ISSUE: begin
                if (!empty) begin
                    rd_en   = 1'b1;
                    state_d = WAIT;
`ifdef FIFO_BURST_READER_PREFETCH_EN
                    issued_d = issued + LEN_W'(1);
`endif
                end
            end

            WAIT: begin
                // rd_err wins over rd_ack; a missing response is also fatal.
                if (rd_err) begin
                    state_d = ERROR;
                end else if (rd_ack) begin
                    m_data_d    = d_out;
                    m_valid_d   = 1'b1;
                    remaining_d = remaining_dec;
                    state_d     = HOLD;
                end else begin
                    state_d = ERROR;
                end
            end

            HOLD: begin
`ifdef FIFO_BURST_READER_PREFETCH_EN
                rd_en  = pf_issue;
                pend_d = pf_issue;
                if (pf_issue) issued_d = issued + LEN_W'(1);
                if (pf_bad)   pf_err_d = 1'b1;
                if (xfer) begin
                    if (skid_v) begin
                        m_data_d    = skid;
                        m_valid_d   = 1'b1;
                        skid_v_d    = 1'b0;
                        remaining_d = remaining_dec;
                    end else if (pf_good) begin
                        m_data_d    = d_out;
                        m_valid_d   = 1'b1;
                        remaining_d = remaining_dec;
                    end else begin
                        m_valid_d = 1'b0;
                        if (pf_err || pf_bad) state_d = ERROR;
                        else if (pf_issue)    state_d = HOLD;
                        else if (remaining == '0) state_d = DONE;
                        else                  state_d = ISSUE;
                    end
                end else begin
                    // Without a transfer, a returning word parks in the skid,
                    // or fills m_data directly when the output slot is empty.
                    if (pf_good) begin
                        if (m_valid) begin
                            skid_d   = d_out;
                            skid_v_d = 1'b1;
                        end else begin
                            m_data_d    = d_out;
                            m_valid_d   = 1'b1;
                            remaining_d = remaining_dec;
                        end
                    end
                    if (!m_valid && (pf_err || pf_bad)) state_d = ERROR;
                end
`else
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    state_d   = (remaining == '0) ? DONE : ISSUE;
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            ERROR: begin
                m_valid_d = 1'b0;
`ifdef FIFO_BURST_READER_PREFETCH_EN
                skid_v_d = 1'b0;
`endif
                if (clr) state_d = IDLE;
            end

            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small behavioural 8-deep FIFO as its read-port partner.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  burst_len;
    logic        clr;
    logic        empty;
    logic        rd_ack;
    logic        rd_err;
    logic [31:0] d_out;
    logic        rd_en;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic        err;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_W(32), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .burst_len(burst_len), .clr(clr),
        .empty(empty), .rd_ack(rd_ack), .rd_err(rd_err), .d_out(d_out), .rd_en(rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .busy(busy),
        .done(done), .err(err)
    );

    // FIFO read port: one-cycle read latency, reset together with the reader.
    logic [31:0] fmem [0:7];
    logic [3:0]  fcnt;
    logic [2:0]  fwp, frp;
    logic        rd_err_q;
    logic        force_err;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        do_rd, do_wr;

    assign empty  = (fcnt == 4'd0);
    assign rd_err = rd_err_q | force_err;
    assign do_rd  = rd_en && (fcnt != 4'd0);
    assign do_wr  = wr_en && (fcnt != 4'd8);

    always @(posedge clk) begin
        if (reset) begin
            fcnt     <= 4'd0;
            fwp      <= 3'd0;
            frp      <= 3'd0;
            rd_ack   <= 1'b0;
            rd_err_q <= 1'b0;
            d_out    <= 32'd0;
        end else begin
            rd_ack   <= do_rd;
            rd_err_q <= rd_en && (fcnt == 4'd0);
            d_out    <= fmem[frp];
            if (do_rd) frp <= frp + 3'd1;
            if (do_wr) begin
                fmem[fwp] <= wr_data;
                fwp       <= fwp + 3'd1;
            end
            fcnt <= fcnt + {3'd0, do_wr} - {3'd0, do_rd};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [31:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int busy_cnt, rd_cnt, done_cnt, done_at, nw;
        logic [31:0] words [0:3];

        reset = 1'b1; start = 1'b0; burst_len = 8'd0; clr = 1'b0;
        m_ready = 1'b0; force_err = 1'b0; wr_en = 1'b0; wr_data = 32'd0;

        // Reset held two cycles
        tick(); tick();
        reset = 1'b0;
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Three-word burst with m_ready held high
        push(32'hA1); push(32'hB2); push(32'hC3);
        burst_len = 8'd3; start = 1'b1; m_ready = 1'b1;
        busy_cnt = 0; rd_cnt = 0; done_cnt = 0; done_at = 0; nw = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = 1'b0;
            burst_len = 8'd7;
            if (busy) busy_cnt++;
            if (rd_en) rd_cnt++;
            if (done) begin done_cnt++; done_at = c; end
            if (m_valid && m_ready && nw < 4) begin words[nw] = m_data; nw++; end
        end
        chk("b3_busy_cycles", busy_cnt, 32'd10);
        chk("b3_rd_pulses", rd_cnt, 32'd3);
        chk("b3_done_pulses", done_cnt, 32'd1);
        chk("b3_done_cycle", done_at, 32'd10);
        chk("b3_words", nw, 32'd3);
        chk("b3_word0", words[0], 32'hA1);
        chk("b3_word1", words[1], 32'hB2);
        chk("b3_word2", words[2], 32'hC3);

        // Backpressure in HOLD
        push(32'hA1);
        burst_len = 8'd1; start = 1'b1; m_ready = 1'b0;
        tick(); start = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_m_valid", {31'd0, m_valid}, 32'd1);
            chk("bp_m_data", m_data, 32'hA1);
            chk("bp_rd_en", {31'd0, rd_en}, 32'd0);
        end
        m_ready = 1'b1;
        tick();
        chk("bp_done", {31'd0, done}, 32'd1);
        chk("bp_m_valid_after", {31'd0, m_valid}, 32'd0);
        tick();
        chk("bp_idle", {31'd0, busy}, 32'd0);

        // Start on an empty FIFO; words arrive late
        burst_len = 8'd2; start = 1'b1; m_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick(); start = 1'b0;
            chk("st_rd_en_empty", {31'd0, rd_en}, 32'd0);
            chk("st_busy", {31'd0, busy}, 32'd1);
        end
        push(32'h11);
        chk("st_rd_en_1", {31'd0, rd_en}, 32'd1);
        tick(); tick();
        chk("st_m_valid_1", {31'd0, m_valid}, 32'd1);
        chk("st_m_data_1", m_data, 32'h11);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("st_stall_rd_en", {31'd0, rd_en}, 32'd0);
        end
        push(32'h22);
        chk("st_rd_en_2", {31'd0, rd_en}, 32'd1);
        tick(); tick();
        chk("st_m_data_2", m_data, 32'h22);
        tick();
        chk("st_done", {31'd0, done}, 32'd1);
        tick();
        chk("st_idle", {31'd0, busy}, 32'd0);

        // Read error in WAIT
        push(32'h33);
        burst_len = 8'd1; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        force_err = 1'b1;
        tick();
        force_err = 1'b0;
        chk("er_err", {31'd0, err}, 32'd1);
        chk("er_m_valid", {31'd0, m_valid}, 32'd0);
        chk("er_rd_en", {31'd0, rd_en}, 32'd0);
        start = 1'b1;
        tick(); start = 1'b0;
        chk("er_start_ignored", {31'd0, err}, 32'd1);
        clr = 1'b1;
        tick(); clr = 1'b0;
        chk("er_clr_err", {31'd0, err}, 32'd0);
        chk("er_clr_busy", {31'd0, busy}, 32'd0);

        // Zero-length burst
        burst_len = 8'd0; start = 1'b1;
        chk("z_rd_en_0", {31'd0, rd_en}, 32'd0);
        tick(); start = 1'b0;
        chk("z_done", {31'd0, done}, 32'd1);
        chk("z_rd_en_1", {31'd0, rd_en}, 32'd0);
        tick();
        chk("z_done_off", {31'd0, done}, 32'd0);
        chk("z_rd_en_2", {31'd0, rd_en}, 32'd0);

        // Reset while holding a word
        push(32'h44);
        burst_len = 8'd1; start = 1'b1; m_ready = 1'b0;
        tick(); start = 1'b0;
        tick(); tick();
        chk("rh_m_valid_pre", {31'd0, m_valid}, 32'd1);
        reset = 1'b1;
        tick(); reset = 1'b0;
        chk("rh_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rh_busy", {31'd0, busy}, 32'd0);
        chk("rh_m_data", m_data, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
